// File: rtl/reset_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_ctrl
// Brief    : Power-on and round-robin soft-reset sequencer with staggered
//            release of NUM_OUT active-high reset outputs.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer_ctrl #(
    parameter int NUM_OUT     = 3,
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 5,
    parameter int SOFT_HOLD   = 4,
    parameter int STAGE_GAP   = 2,
    localparam int c_GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               CLK_IN,
    input  logic               RESETn,
    input  logic [NUM_REQ-1:0] SOFT_REQ,
    output logic [NUM_OUT-1:0] RESET_OUT,
    output logic [NUM_REQ-1:0] SOFT_ACK,
    output logic [c_GID_W-1:0] GRANT_ID,
    output logic               READY,
    output logic               BUSY
);

    localparam int c_MAX_HS  = (HOLD_CYCLES > SOFT_HOLD) ? HOLD_CYCLES : SOFT_HOLD;
    localparam int c_CNT_MAX = (c_MAX_HS > STAGE_GAP) ? c_MAX_HS : STAGE_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_STG_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [1:0] c_ST_ASSERT      = 2'd0;
    localparam logic [1:0] c_ST_SOFT_ASSERT = 2'd1;
    localparam logic [1:0] c_ST_RELEASE     = 2'd2;
    localparam logic [1:0] c_ST_RUN         = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_STG_W-1:0] r_stage;
    logic [c_GID_W-1:0] r_ptr;
    logic [c_GID_W-1:0] r_gid;
    logic               r_soft;
    logic [NUM_OUT-1:0] r_reset_out;
    logic [NUM_REQ-1:0] r_soft_ack;
    logic               r_ready;
    logic               r_busy;

    logic               w_found;
    logic [c_GID_W-1:0] w_grant_idx;
    logic [c_GID_W-1:0] w_cand;
    logic               w_hold_done;
    logic               w_gap_done;
    logic               w_stage_rel;
    logic               w_last;

    // Round-robin search: scan downwards so the lowest offset from r_ptr wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = c_GID_W'((int'(r_ptr) + i) % NUM_REQ);
            if (SOFT_REQ[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_hold_done = ((r_state == c_ST_ASSERT) && r_sync[1] &&
                       (r_cnt == c_CNT_W'(HOLD_CYCLES - 1))) ||
                      ((r_state == c_ST_SOFT_ASSERT) &&
                       (r_cnt == c_CNT_W'(SOFT_HOLD - 1)));
        w_gap_done  = (r_state == c_ST_RELEASE) && (r_cnt == c_CNT_W'(STAGE_GAP - 1));
        w_stage_rel = w_hold_done || w_gap_done;
        w_last      = w_hold_done ? (NUM_OUT == 1)
                                  : (int'(r_stage) + 1 == NUM_OUT - 1);
    end

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= c_ST_ASSERT;
            r_sync      <= '0;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_soft      <= 1'b0;
            r_reset_out <= '1;
            r_soft_ack  <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], 1'b1};
            r_soft_ack <= '0;
            case (r_state)
                c_ST_ASSERT: begin
                    if (r_sync[1]) r_cnt <= r_cnt + c_CNT_W'(1);
                end
                c_ST_SOFT_ASSERT,
                c_ST_RELEASE: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                default: begin
                    // An ack in flight masks the sample so its requester can drop.
                    if (w_found && (r_soft_ack == '0)) begin
                        r_reset_out <= '1;
                        r_gid       <= w_grant_idx;
                        r_ptr       <= (w_grant_idx == c_GID_W'(NUM_REQ - 1)) ?
                                       '0 : w_grant_idx + c_GID_W'(1);
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_soft      <= 1'b1;
                        r_cnt       <= '0;
                        r_stage     <= '0;
                        r_state     <= c_ST_SOFT_ASSERT;
                    end
                end
            endcase

            if (w_stage_rel) begin
                r_reset_out <= r_reset_out << 1;
                r_cnt       <= '0;
                r_stage     <= w_hold_done ? '0 : r_stage + c_STG_W'(1);
                if (w_last) begin
                    r_state <= c_ST_RUN;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_soft  <= 1'b0;
                    if (r_soft) r_soft_ack <= NUM_REQ'(1) << r_gid;
                end else begin
                    r_state <= c_ST_RELEASE;
                end
            end
        end
    end

    assign RESET_OUT = r_reset_out;
    assign SOFT_ACK  = r_soft_ack;
    assign GRANT_ID  = r_gid;
    assign READY     = r_ready;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire
